ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
Pipeline hazard and forwarding controller for the execute stage. It keeps its own shadow pipeline of register-usage metadata for the EX, MEM and WB stages. From that state it produces the EX-stage forwarding selects (forward1/forward2) and the ID-stage stall request (hazard). It also counts stall cycles for performance monitoring.

Parameters:
REG_W, 4, register index width (16 architectural registers)
CNT_W, 16, stall counter width

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
freeze  input  1  memory-stall freeze; holds all internal state
flush  input  1  branch taken in EX; wrong-path instruction in ID is killed
fwd_en  input  1  1 = forwarding enabled, 0 = stall-only mode
ID_valid  input  1  ID stage holds a real instruction
ID_src1  input  REG_W  first source register (Rn)
ID_src2  input  REG_W  second source register (Rm, or Rd for stores)
ID_two_src  input  1  ID_src2 is actually read
ID_dest  input  REG_W  destination register
ID_WB_EN  input  1  instruction writes back
ID_MEM_R_EN  input  1  instruction is a load
hazard  output  1  stall IF/ID and insert a bubble into EX
forward1  output  2  EX operand-1 select: 00 Val_Rn, 01 MEM ALU result, 10 WB value
forward2  output  2  EX operand-2 select, same encoding
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Shadow slots (registers):
  - EX: {valid, src1, src2, two_src, dest, wb_en, mem_r_en}
  - MEM: {valid, dest, wb_en, mem_r_en}
  - WB: {valid, dest, wb_en}
- Reset (RST=1 at an edge): all slot valid/wb_en/mem_r_en cleared. stall_count=0. This forces hazard=0 and forward1=forward2=00 from the next cycle. Reset mid-stall drops the stall and discards all tracked instructions.
- Advance (freeze=0):
  - WB <= MEM; MEM <= EX.
  - EX <= bubble (valid=0, wb_en=0, mem_r_en=0) if flush=1, hazard=1 or ID_valid=0; otherwise EX <= ID fields.
- Freeze (freeze=1): all slots and stall_count hold. Freeze overrides flush; the flush source must hold flush until freeze drops.
- Slot matching:
  - A slot "matches" register r when slot.valid & slot.wb_en & (slot.dest == r).
  - src2 participates only when two_src=1.
- hazard (combinational):
  - Forced to 0 when flush=1 or ID_valid=0.
  - If fwd_en=0: hazard=1 when ID_src1, or ID_src2 with ID_two_src, matches the EX or MEM slot.
  - If fwd_en=1: hazard=1 only for load-use, i.e. the EX slot has mem_r_en=1 and matches a used ID source.
  - The WB slot never causes a hazard, because the register file writes in the first half-cycle.
- forward1 (combinational, from the EX slot):
  - 00 when fwd_en=0 or the EX slot is invalid.
  - Otherwise 01 if MEM matches EX.src1 and MEM.mem_r_en=0; else 10 if WB matches EX.src1; else 00.
  - MEM has priority over WB.
- forward2: same rule applied to EX.src2, gated by EX.two_src (00 when two_src=0).
- Code 11 is never produced.
- stall_count: increments on every edge with hazard=1 and freeze=0; saturates at all-ones and does not wrap.
- Load-use sequence: the load is in EX and the dependent instruction is in ID, so hazard=1 for exactly one cycle (bubble into EX). Next cycle the load is in MEM and the EX slot is the bubble, so hazard=0. The dependent instruction then enters EX with the load in WB and gets forward=10.
- All outputs are purely a function of the slots, the ID inputs, fwd_en and flush. There are no other internal FSM states.

Test Plan:
- Reset: RST=1 for 2 cycles with random ID inputs → hazard=0, forward1=forward2=00, stall_count=0. One cycle after release, still 00.
- EX→EX forward: fwd_en=1, issue ADD R1 then SUB R2,R1,R3 back-to-back → hazard never 1. While SUB is in EX, forward1=01 and forward2=00.
- WB forward and priority: fwd_en=1, issue ADD R4; MOV R4; ORR R5,R4,R4 (two_src) → ORR in EX sees forward1=forward2=01 (MOV wins over ADD). With a NOP in place of MOV → forward1=forward2=10.
- Load-use: fwd_en=1, issue LDR R6 then ADD R7,R6,R0 → hazard=1 for exactly 1 cycle, stall_count=1. ADD in EX gets forward1=10.
- Stall-only mode: fwd_en=0, issue ADD R1 then CMP R1 → hazard=1 for 2 cycles, stall_count +2, forward always 00.
- Freeze/flush: assert freeze for 3 cycles during a load-use hazard → hazard stays 1, stall_count unchanged, slots hold. With flush=1 and a matching ID instruction → hazard=0 and the EX slot becomes a bubble.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
// Execute-stage hazard and forwarding controller. It keeps a shadow copy of
// the register-usage metadata for the instructions in EX, MEM and WB. From
// that copy it derives the EX operand forwarding selects and the ID stall
// request. A saturating counter records how many cycles were spent stalling.
module ex_hazard_ctrl #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             freeze,
    input  logic             flush,
    input  logic             fwd_en,
    input  logic             ID_valid,
    input  logic [REG_W-1:0] ID_src1,
    input  logic [REG_W-1:0] ID_src2,
    input  logic             ID_two_src,
    input  logic [REG_W-1:0] ID_dest,
    input  logic             ID_WB_EN,
    input  logic             ID_MEM_R_EN,
    output logic             hazard,
    output logic [1:0]       forward1,
    output logic [1:0]       forward2,
    output logic [CNT_W-1:0] stall_count
);

    // Forwarding select encodings seen by the EX operand muxes
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // EX slot (_p0)
    logic             vld_p0;
    logic             wb_en_p0;
    logic             mem_r_en_p0;
    logic [REG_W-1:0] src1_p0;
    logic [REG_W-1:0] src2_p0;
    logic             two_src_p0;
    logic [REG_W-1:0] dest_p0;

    // MEM slot (_p1)
    logic             vld_p1;
    logic             wb_en_p1;
    logic             mem_r_en_p1;
    logic [REG_W-1:0] dest_p1;

    // WB slot (_p2)
    logic             vld_p2;
    logic             wb_en_p2;
    logic [REG_W-1:0] dest_p2;

    logic ex_hit;
    logic mem_hit;
    logic advance;
    logic issue;

    // A slot produces register r only if it is a live instruction that writes back to r
    function automatic logic slot_hit(
        input logic             vld,
        input logic             wb_en,
        input logic [REG_W-1:0] dest,
        input logic [REG_W-1:0] r
    );
        return vld & wb_en & (dest == r);
    endfunction

    // Saturating increment: the counter sticks at all-ones rather than wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&cnt) ? cnt : cnt + one;
    endfunction

    assign advance = ~freeze;
    // A real instruction leaves ID only when it is not killed and not stalled
    assign issue   = ID_valid & ~flush & ~hazard;

    // Dependency of the ID instruction on the older instructions in EX and MEM
    always_comb begin
        ex_hit  = slot_hit(vld_p0, wb_en_p0, dest_p0, ID_src1)
                | (ID_two_src & slot_hit(vld_p0, wb_en_p0, dest_p0, ID_src2));
        mem_hit = slot_hit(vld_p1, wb_en_p1, dest_p1, ID_src1)
                | (ID_two_src & slot_hit(vld_p1, wb_en_p1, dest_p1, ID_src2));
    end

    // Stall request: load-use only when forwarding, any EX/MEM dependency otherwise.
    // WB never stalls because the register file writes in the first half-cycle.
    always_comb begin
        hazard = 1'b0;
        if (ID_valid && !flush) begin
            if (fwd_en) begin
                hazard = ex_hit & mem_r_en_p0;
            end else begin
                hazard = ex_hit | mem_hit;
            end
        end
    end

    // Operand selects for the instruction in EX; MEM has priority over WB and a
    // load still in MEM has no data yet, so it is never a forwarding source
    always_comb begin
        forward1 = SEL_RF;
        forward2 = SEL_RF;
        if (fwd_en && vld_p0) begin
            if (slot_hit(vld_p1, wb_en_p1, dest_p1, src1_p0) && !mem_r_en_p1) begin
                forward1 = SEL_MEM;
            end else if (slot_hit(vld_p2, wb_en_p2, dest_p2, src1_p0)) begin
                forward1 = SEL_WB;
            end
            if (two_src_p0) begin
                if (slot_hit(vld_p1, wb_en_p1, dest_p1, src2_p0) && !mem_r_en_p1) begin
                    forward2 = SEL_MEM;
                end else if (slot_hit(vld_p2, wb_en_p2, dest_p2, src2_p0)) begin
                    forward2 = SEL_WB;
                end
            end
        end
    end

    // Control state: slot valid/qualifier bits and the stall counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p0      <= 1'b0;
            wb_en_p0    <= 1'b0;
            mem_r_en_p0 <= 1'b0;
            vld_p1      <= 1'b0;
            wb_en_p1    <= 1'b0;
            mem_r_en_p1 <= 1'b0;
            vld_p2      <= 1'b0;
            wb_en_p2    <= 1'b0;
            stall_count <= '0;
        end else if (advance) begin
            // ID -> EX: bubble when killed, stalled or empty
            vld_p0      <= issue;
            wb_en_p0    <= issue & ID_WB_EN;
            mem_r_en_p0 <= issue & ID_MEM_R_EN;
            // EX -> MEM
            vld_p1      <= vld_p0;
            wb_en_p1    <= wb_en_p0;
            mem_r_en_p1 <= mem_r_en_p0;
            // MEM -> WB
            vld_p2      <= vld_p1;
            wb_en_p2    <= wb_en_p1;
            if (hazard) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end

    // Register indices; qualified by the valid bits so they need no reset
    always_ff @(posedge CLK) begin
        if (advance) begin
            // ID -> EX
            src1_p0    <= ID_src1;
            src2_p0    <= ID_src2;
            two_src_p0 <= ID_two_src;
            dest_p0    <= ID_dest;
            // EX -> MEM
            dest_p1    <= dest_p0;
            // MEM -> WB
            dest_p2    <= dest_p1;
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Testbench for ex_hazard_ctrl: directed scenarios plus randomized traffic
// checked against an instruction-level model of the EX/MEM/WB pipeline.
module tb_ex_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        fwd_en = 1'b1;
    logic        ID_valid = 1'b0;
    logic [3:0]  ID_src1 = '0;
    logic [3:0]  ID_src2 = '0;
    logic        ID_two_src = 1'b0;
    logic [3:0]  ID_dest = '0;
    logic        ID_WB_EN = 1'b0;
    logic        ID_MEM_R_EN = 1'b0;
    logic        hazard;
    logic [1:0]  forward1;
    logic [1:0]  forward2;
    logic [15:0] stall_count;

    int total = 0;
    int passed = 0;

    ex_hazard_ctrl #(.REG_W(4), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .freeze(freeze), .flush(flush), .fwd_en(fwd_en),
        .ID_valid(ID_valid), .ID_src1(ID_src1), .ID_src2(ID_src2),
        .ID_two_src(ID_two_src), .ID_dest(ID_dest), .ID_WB_EN(ID_WB_EN),
        .ID_MEM_R_EN(ID_MEM_R_EN), .hazard(hazard), .forward1(forward1),
        .forward2(forward2), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    // Instruction record held by the model for each in-flight instruction
    typedef struct packed {
        bit       v;
        bit [3:0] s1;
        bit [3:0] s2;
        bit [3:0] d;
        bit       two;
        bit       wb;
        bit       ld;
    } instr_t;

    instr_t      m_ex, m_mem, m_wb;
    int unsigned m_cnt = 0;

    function automatic bit writes(instr_t p, bit [3:0] r);
        return p.v && p.wb && (p.d == r);
    endfunction

    function automatic bit reads(instr_t p, bit [3:0] r);
        return (p.s1 == r) || (p.two && p.s2 == r);
    endfunction

    // Does the instruction currently in ID have to wait?
    function automatic bit exp_hazard();
        instr_t id;
        if (!ID_valid || flush) return 1'b0;
        id = '{v: 1'b1, s1: ID_src1, s2: ID_src2, d: ID_dest, two: ID_two_src,
               wb: ID_WB_EN, ld: ID_MEM_R_EN};
        if (m_ex.v && m_ex.wb && reads(id, m_ex.d)) begin
            if (!fwd_en || m_ex.ld) return 1'b1;
        end
        if (!fwd_en && m_mem.v && m_mem.wb && reads(id, m_mem.d)) return 1'b1;
        return 1'b0;
    endfunction

    // Where operand register r of the EX instruction should come from
    function automatic bit [1:0] exp_fwd(bit [3:0] r, bit used);
        if (!fwd_en || !m_ex.v || !used) return 2'd0;
        if (writes(m_mem, r) && !m_mem.ld) return 2'd1;
        if (writes(m_wb, r)) return 2'd2;
        return 2'd0;
    endfunction

    // One rising edge: model follows the pipeline, then settle past the edge
    task automatic tick();
        bit h;
        @(posedge CLK);
        if (RST) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
        end else if (!freeze) begin
            h = exp_hazard();
            if (h && m_cnt < 65535) m_cnt++;
            m_wb  = m_mem;
            m_mem = m_ex;
            if (flush || h || !ID_valid) m_ex = '0;
            else m_ex = '{v: 1'b1, s1: ID_src1, s2: ID_src2, d: ID_dest,
                          two: ID_two_src, wb: ID_WB_EN, ld: ID_MEM_R_EN};
        end
        #1;
    endtask

    task automatic set_id(bit v, bit [3:0] s1, bit [3:0] s2, bit two, bit [3:0] d,
                          bit wb, bit ld);
        ID_valid = v; ID_src1 = s1; ID_src2 = s2; ID_two_src = two;
        ID_dest = d; ID_WB_EN = wb; ID_MEM_R_EN = ld;
    endtask

    task automatic drain();
        freeze = 1'b0; flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        set_id(1, 4'($urandom), 4'($urandom), 1, 4'($urandom), 1, 1'($urandom));
        tick();
        tick();
        @(negedge CLK);
        total++; if (hazard !== 1'b0) $display("FAIL reset_hazard: got %b want 0", hazard); else passed++;
        total++; if (forward1 !== 2'b00) $display("FAIL reset_fwd1: got %b want 00", forward1); else passed++;
        total++; if (forward2 !== 2'b00) $display("FAIL reset_fwd2: got %b want 00", forward2); else passed++;
        total++; if (stall_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", stall_count); else passed++;
        RST = 1'b0;
        tick();
        @(negedge CLK);
        total++; if (forward1 !== 2'b00) $display("FAIL post_reset_fwd1: got %b want 00", forward1); else passed++;
        total++; if (forward2 !== 2'b00) $display("FAIL post_reset_fwd2: got %b want 00", forward2); else passed++;
        total++; if (stall_count !== 16'd0) $display("FAIL post_reset_count: got %0d want 0", stall_count); else passed++;
    endtask

    task automatic test_ex_forward();
        fwd_en = 1'b1;
        drain();
        set_id(1, 2, 3, 1, 1, 1, 0);            // ADD R1,R2,R3
        @(negedge CLK);
        total++; if (hazard !== 1'b0) $display("FAIL exfwd_haz_add: got %b want 0", hazard); else passed++;
        tick();
        set_id(1, 1, 3, 1, 2, 1, 0);            // SUB R2,R1,R3
        @(negedge CLK);
        total++; if (hazard !== 1'b0) $display("FAIL exfwd_haz_sub: got %b want 0", hazard); else passed++;
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        total++; if (forward1 !== 2'b01) $display("FAIL exfwd_fwd1: got %b want 01", forward1); else passed++;
        total++; if (forward2 !== 2'b00) $display("FAIL exfwd_fwd2: got %b want 00", forward2); else passed++;
    endtask

    task automatic test_wb_forward();
        fwd_en = 1'b1;
        drain();
        set_id(1, 1, 2, 1, 4, 1, 0); tick();    // ADD R4
        set_id(1, 0, 0, 0, 4, 1, 0); tick();    // MOV R4
        set_id(1, 4, 4, 1, 5, 1, 0); tick();    // ORR R5,R4,R4
        set_id(0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        total++; if (forward1 !== 2'b01) $display("FAIL prio_fwd1: got %b want 01", forward1); else passed++;
        total++; if (forward2 !== 2'b01) $display("FAIL prio_fwd2: got %b want 01", forward2); else passed++;
        drain();
        set_id(1, 1, 2, 1, 4, 1, 0); tick();    // ADD R4
        set_id(0, 0, 0, 0, 0, 0, 0); tick();    // NOP
        set_id(1, 4, 4, 1, 5, 1, 0); tick();    // ORR R5,R4,R4
        set_id(0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        total++; if (forward1 !== 2'b10) $display("FAIL wb_fwd1: got %b want 10", forward1); else passed++;
        total++; if (forward2 !== 2'b10) $display("FAIL wb_fwd2: got %b want 10", forward2); else passed++;
    endtask

    task automatic test_load_use();
        int unsigned c0;
        fwd_en = 1'b1;
        drain();
        set_id(1, 8, 0, 0, 6, 1, 1); tick();    // LDR R6,[R8]
        set_id(1, 6, 0, 1, 7, 1, 0);            // ADD R7,R6,R0
        c0 = m_cnt;
        @(negedge CLK);
        total++; if (hazard !== 1'b1) $display("FAIL lu_haz_first: got %b want 1", hazard); else passed++;
        tick();
        @(negedge CLK);
        total++; if (hazard !== 1'b0) $display("FAIL lu_haz_second: got %b want 0", hazard); else passed++;
        total++; if (stall_count !== 16'(c0 + 1)) $display("FAIL lu_count: got %0d want %0d", stall_count, c0 + 1); else passed++;
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        total++; if (forward1 !== 2'b10) $display("FAIL lu_fwd1: got %b want 10", forward1); else passed++;
        total++; if (forward2 !== 2'b00) $display("FAIL lu_fwd2: got %b want 00", forward2); else passed++;
    endtask

    task automatic test_stall_only();
        int unsigned c0;
        fwd_en = 1'b0;
        drain();
        set_id(1, 2, 3, 1, 1, 1, 0); tick();    // ADD R1
        set_id(1, 1, 9, 1, 0, 0, 0);            // CMP R1,R9
        c0 = m_cnt;
        @(negedge CLK);
        total++; if (hazard !== 1'b1) $display("FAIL so_haz_c1: got %b want 1", hazard); else passed++;
        total++; if (forward1 !== 2'b00) $display("FAIL so_fwd1_c1: got %b want 00", forward1); else passed++;
        tick();
        @(negedge CLK);
        total++; if (hazard !== 1'b1) $display("FAIL so_haz_c2: got %b want 1", hazard); else passed++;
        tick();
        @(negedge CLK);
        total++; if (hazard !== 1'b0) $display("FAIL so_haz_c3: got %b want 0", hazard); else passed++;
        total++; if (stall_count !== 16'(c0 + 2)) $display("FAIL so_count: got %0d want %0d", stall_count, c0 + 2); else passed++;
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        total++; if (forward1 !== 2'b00) $display("FAIL so_fwd1_ex: got %b want 00", forward1); else passed++;
        total++; if (forward2 !== 2'b00) $display("FAIL so_fwd2_ex: got %b want 00", forward2); else passed++;
        fwd_en = 1'b1;
    endtask

    task automatic test_freeze_flush();
        int unsigned c0;
        fwd_en = 1'b1;
        drain();
        set_id(1, 8, 0, 0, 6, 1, 1); tick();    // LDR R6
        set_id(1, 6, 0, 1, 7, 1, 0);            // ADD R7,R6,R0
        c0 = m_cnt;
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge CLK);
            total++; if (hazard !== 1'b1) $display("FAIL frz_haz_%0d: got %b want 1", i, hazard); else passed++;
            total++; if (stall_count !== 16'(c0)) $display("FAIL frz_count_%0d: got %0d want %0d", i, stall_count, c0); else passed++;
        end
        freeze = 1'b0;
        tick();
        @(negedge CLK);
        total++; if (hazard !== 1'b0) $display("FAIL frz_release_haz: got %b want 0", hazard); else passed++;
        total++; if (stall_count !== 16'(c0 + 1)) $display("FAIL frz_release_count: got %0d want %0d", stall_count, c0 + 1); else passed++;
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        total++; if (forward1 !== 2'b10) $display("FAIL frz_fwd1: got %b want 10", forward1); else passed++;

        drain();
        set_id(1, 8, 0, 0, 6, 1, 1); tick();    // LDR R6
        set_id(1, 6, 0, 1, 7, 1, 0);            // wrong-path ADD R7,R6,R0
        flush = 1'b1;
        @(negedge CLK);
        total++; if (hazard !== 1'b0) $display("FAIL flush_haz: got %b want 0", hazard); else passed++;
        tick();
        flush = 1'b0;
        fwd_en = 1'b0;
        set_id(1, 7, 7, 1, 9, 1, 0);            // reads R7: only the killed ADD wrote it
        @(negedge CLK);
        total++; if (hazard !== 1'b0) $display("FAIL flush_bubble: got %b want 0", hazard); else passed++;
        fwd_en = 1'b1;
    endtask

    task automatic test_reset_mid_stall();
        fwd_en = 1'b1;
        drain();
        set_id(1, 8, 0, 0, 6, 1, 1); tick();
        set_id(1, 6, 0, 0, 7, 1, 0);
        @(negedge CLK);
        total++; if (hazard !== 1'b1) $display("FAIL rms_haz_before: got %b want 1", hazard); else passed++;
        RST = 1'b1;
        tick();
        @(negedge CLK);
        total++; if (hazard !== 1'b0) $display("FAIL rms_haz_after: got %b want 0", hazard); else passed++;
        total++; if (stall_count !== 16'd0) $display("FAIL rms_count: got %0d want 0", stall_count); else passed++;
        RST = 1'b0;
        drain();
    endtask

    task automatic test_random();
        bit       eh;
        bit [1:0] ef1, ef2;
        int       errs;
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) fwd_en = 1'($urandom);
            freeze = ($urandom_range(0, 9) == 0);
            // a pending flush is held while frozen
            if (!(freeze && flush)) flush = ($urandom_range(0, 9) == 0);
            set_id($urandom_range(0, 4) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   1'($urandom), 4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0);
            eh  = exp_hazard();
            ef1 = exp_fwd(m_ex.s1, 1'b1);
            ef2 = exp_fwd(m_ex.s2, m_ex.two);
            @(negedge CLK);
            total++;
            if (hazard !== eh || forward1 !== ef1 || forward2 !== ef2 || stall_count !== 16'(m_cnt)) begin
                if (errs < 10)
                    $display("FAIL rand_cyc%0d: got haz=%b f1=%b f2=%b cnt=%0d want haz=%b f1=%b f2=%b cnt=%0d",
                             n, hazard, forward1, forward2, stall_count, eh, ef1, ef2, m_cnt);
                errs++;
            end else passed++;
            tick();
        end
        freeze = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        m_ex = '0; m_mem = '0; m_wb = '0;
        test_reset();
        test_ex_forward();
        test_wb_forward();
        test_load_use();
        test_stall_only();
        test_freeze_flush();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
